// File: rtl/mk8_gpio_pkg.sv
// Shared constants for the MK8 GPIO input path: default bus width, synchroniser
// depth and the 1 ms debounce window at 50 MHz.
package mk8_gpio_pkg;

    localparam int MK8_GPIO_WIDTH   = 8;
    localparam int MK8_DEBOUNCE_1MS = 50000;
    localparam int MK8_SYNC_STAGES  = 2;

    // Counter width able to hold 0..cycles, so the terminal value never wraps.
    function automatic int mk8_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/mk8_debounce_bit.sv
// One debounced input bit: synchroniser chain, consecutive-mismatch counter,
// stable output bit and one-cycle rise/fall pulse flops.
module mk8_debounce_bit
    import mk8_gpio_pkg::*;
#(
    parameter int SYNC_STAGES     = MK8_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = MK8_DEBOUNCE_1MS
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic i_pin,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = mk8_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_syn;

    assign w_syn = r_sync[SYNC_STAGES-1];

    // The synchroniser always shifts; en only gates the counter and the accepted state.
    // Pulses default low every edge so they last exactly one cycle, and stay low while frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (en) begin
                if (w_syn == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_MAX) begin
                    r_stable <= w_syn;
                    r_cnt    <= '0;
                    r_rise   <= w_syn;
                    r_fall   <= ~w_syn;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;

endmodule

// File: rtl/mk8_gpio_input_debouncer.sv
// Debounced input conditioner feeding the LED/GPIO PIO in_port: WIDTH independent
// debounce bits plus a combined change flag for interrupt logic.
module mk8_gpio_input_debouncer
    import mk8_gpio_pkg::*;
#(
    parameter int WIDTH           = MK8_GPIO_WIDTH,
    parameter int SYNC_STAGES     = MK8_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = MK8_DEBOUNCE_1MS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             changed
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            mk8_debounce_bit #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_bit (
                .clk     (clk),
                .reset   (reset),
                .en      (en),
                .i_pin   (pin_in[gi]),
                .o_stable(in_port[gi]),
                .o_rise  (rise_pulse[gi]),
                .o_fall  (fall_pulse[gi])
            );
        end
    endgenerate

    // Built only from registered pulses, so pin_in never reaches an output combinationally.
    assign changed = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_mk8_gpio_input_debouncer.sv
// Directed bench for mk8_gpio_input_debouncer with a short debounce window;
// expected outputs are queued as each step is driven and checked after the edge.
module tb_mk8_gpio_input_debouncer;

    localparam int WIDTH           = 8;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;

    typedef struct {
        logic [7:0] inPort;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       changed;
        string      tag;
    } expect_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [WIDTH-1:0] pinIn;
    logic [WIDTH-1:0] inPort;
    logic [WIDTH-1:0] risePulse;
    logic [WIDTH-1:0] fallPulse;
    logic             changed;

    expect_t expQ[$];
    int      testCount = 0;
    int      failCount = 0;

    always #5 clk = ~clk;

    mk8_gpio_input_debouncer #(
        .WIDTH          (WIDTH),
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .pin_in    (pinIn),
        .in_port   (inPort),
        .rise_pulse(risePulse),
        .fall_pulse(fallPulse),
        .changed   (changed)
    );

    // Pops the oldest expectation and compares it against the current outputs.
    task automatic checkOutput();
        expect_t e;
        logic [24:0] observed;
        logic [24:0] expected;
        testCount++;
        if (expQ.size() == 0) begin
            failCount++;
            $error("[TB] FAIL scoreboard_empty: observed no queued entry, expected one");
            return;
        end
        e = expQ.pop_front();
        observed = {inPort, risePulse, fallPulse, changed};
        expected = {e.inPort, e.rise, e.fall, e.changed};
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed in=%h rise=%h fall=%h chg=%b, expected in=%h rise=%h fall=%h chg=%b",
                   e.tag, inPort, risePulse, fallPulse, changed,
                   e.inPort, e.rise, e.fall, e.changed);
        end
    endtask

    // Drives one cycle of inputs, queues the outputs expected after the next edge, then checks.
    task automatic applyStimulus(input logic rst, input logic enable, input logic [7:0] pin,
                                 input logic [7:0] expIn, input logic [7:0] expRise,
                                 input logic [7:0] expFall, input logic expChg, input string tag);
        expect_t e;
        reset = rst;
        en    = enable;
        pinIn = pin;
        e.inPort  = expIn;
        e.rise    = expRise;
        e.fall    = expFall;
        e.changed = expChg;
        e.tag     = tag;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic holdSteps(input int n, input logic rst, input logic enable,
                             input logic [7:0] pin, input logic [7:0] expIn, input string tag);
        for (int k = 0; k < n; k++)
            applyStimulus(rst, enable, pin, expIn, 8'h00, 8'h00, 1'b0, tag);
    endtask

    task automatic checkNow(input logic [7:0] expIn, input string tag);
        expect_t e;
        e.inPort  = expIn;
        e.rise    = 8'h00;
        e.fall    = 8'h00;
        e.changed = 1'b0;
        e.tag     = tag;
        expQ.push_back(e);
        checkOutput();
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        pinIn = 8'hFF;
        #2;
        checkNow(8'h00, "reset_async");

        // Reset held with all pins high: nothing may leak through.
        holdSteps(10, 1'b1, 1'b1, 8'hFF, 8'h00, "reset_hold");
        holdSteps(3, 1'b0, 1'b1, 8'h00, 8'h00, "post_reset_idle");

        // Clean rising edge on bit 0: accepted at edge SYNC_STAGES+DEBOUNCE_CYCLES = 6.
        holdSteps(5, 1'b0, 1'b1, 8'h01, 8'h00, "clean_wait");
        applyStimulus(1'b0, 1'b1, 8'h01, 8'h01, 8'h01, 8'h00, 1'b1, "clean_update");
        holdSteps(3, 1'b0, 1'b1, 8'h01, 8'h01, "clean_after");

        // Bounce on bit 1: one low cycle restarts the count from zero.
        holdSteps(3, 1'b0, 1'b1, 8'h03, 8'h01, "bounce_high1");
        holdSteps(1, 1'b0, 1'b1, 8'h01, 8'h01, "bounce_low");
        holdSteps(5, 1'b0, 1'b1, 8'h03, 8'h01, "bounce_high2");
        applyStimulus(1'b0, 1'b1, 8'h03, 8'h03, 8'h02, 8'h00, 1'b1, "bounce_update");
        holdSteps(2, 1'b0, 1'b1, 8'h03, 8'h03, "bounce_after");

        // Enable hold on bit 2: freeze after two counts, then finish two edges after re-enable.
        holdSteps(4, 1'b0, 1'b1, 8'h07, 8'h03, "en_count");
        holdSteps(20, 1'b0, 1'b0, 8'h07, 8'h03, "en_frozen");
        holdSteps(1, 1'b0, 1'b1, 8'h07, 8'h03, "en_resume");
        applyStimulus(1'b0, 1'b1, 8'h07, 8'h07, 8'h04, 8'h00, 1'b1, "en_update");
        holdSteps(2, 1'b0, 1'b1, 8'h07, 8'h07, "en_after");

        // Move to 8'hF0, then swap every bit at once to 8'h0F.
        holdSteps(5, 1'b0, 1'b1, 8'hF0, 8'h07, "to_f0_wait");
        applyStimulus(1'b0, 1'b1, 8'hF0, 8'hF0, 8'hF0, 8'h07, 1'b1, "to_f0_update");
        holdSteps(5, 1'b0, 1'b1, 8'h0F, 8'hF0, "simul_wait");
        applyStimulus(1'b0, 1'b1, 8'h0F, 8'h0F, 8'h0F, 8'hF0, 1'b1, "simul_update");
        holdSteps(2, 1'b0, 1'b1, 8'h0F, 8'h0F, "simul_after");

        // Clear to zero, then reset in the middle of a count on bit 7.
        holdSteps(2, 1'b1, 1'b1, 8'h00, 8'h00, "midreset_clear");
        holdSteps(5, 1'b0, 1'b1, 8'h80, 8'h00, "midreset_count");
        reset = 1'b1;
        #2;
        checkNow(8'h00, "midreset_assert");
        holdSteps(2, 1'b1, 1'b1, 8'h80, 8'h00, "midreset_hold");
        holdSteps(5, 1'b0, 1'b1, 8'h80, 8'h00, "midreset_recount");
        applyStimulus(1'b0, 1'b1, 8'h80, 8'h80, 8'h80, 8'h00, 1'b1, "midreset_update");
        holdSteps(2, 1'b0, 1'b1, 8'h80, 8'h80, "midreset_after");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
